// File: rtl/posit_quire_pkg.sv
// Shared constants and FSM encoding for the quire/posit32 (es=2) datapath.
package posit_quire_pkg;
  localparam int QUIRE_W    = 512;
  localparam int SEG_W      = 64;
  localparam int QUIRE_SEGS = 8;
  localparam int FRAC_POS   = 256;
  localparam int MAX_SCALE  = 120;

  localparam logic [31:0] POSIT_NAR    = 32'h8000_0000;
  localparam logic [31:0] POSIT_MAXPOS = 32'h7FFF_FFFF;
  localparam logic [31:0] POSIT_MINPOS = 32'h0000_0001;

  typedef enum logic [2:0] {
    S_IDLE, S_SIGN, S_SCAN, S_NORM, S_ROUND, S_DONE
  } q2p_state_e;
endpackage

// File: rtl/posit_lzc64.sv
// 64-bit leading-zero count from 4-bit nibble counters; returns 64 for zero input.
module posit_lzc64 (
  input  logic [63:0] din,
  output logic [6:0]  lz
);
  logic [15:0]      nz;
  logic [15:0][1:0] nlc;

  for (genvar g = 0; g < 16; g++) begin : g_nib
    logic [3:0] n;
    assign n      = din[4*g +: 4];
    assign nz[g]  = |n;
    assign nlc[g] = n[3] ? 2'd0 : n[2] ? 2'd1 : n[1] ? 2'd2 : 2'd3;
  end

  // Higher nibbles are visited later, so the most significant nonzero one wins.
  always_comb begin
    lz = 7'd64;
    for (int g = 0; g < 16; g++)
      if (nz[g]) lz = 7'((15 - g) * 4) + {5'b0, nlc[g]};
  end
endmodule

// File: rtl/quire_to_posit.sv
// Reads the 512-bit quire segment by segment and rounds it to one posit32 (es=2).
module quire_to_posit
  import posit_quire_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        isInf,
  output logic        rd_en,
  output logic        rd_bank,
  output logic [1:0]  rd_adr,
  input  logic [63:0] rd_data,
  output logic        busy,
  output logic [31:0] posit_out,
  output logic        out_valid
);
  localparam logic signed [10:0] SC_MAX = 11'(MAX_SCALE);
  localparam logic signed [10:0] SC_FP  = 11'(FRAC_POS);

  q2p_state_e state_q, state_d;
  logic        accept;
  logic [3:0]  cnt_q;
  logic        inf_q, sign_q, carry_q, nz_q, stk_q, wstk_q;
  logic [63:0] prev_q, stk_below_q, top_q, next_q, mag;
  logic [2:0]  top_idx_q;
  logic [6:0]  lz;
  logic [126:0] win_q;
  logic signed [10:0] scale_q;

  posit_lzc64 u_lzc (.din(top_q), .lz(lz));

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    rd_bank = 1'b0;
    rd_adr  = 2'd0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SIGN;
      S_SIGN: begin
        rd_en   = 1'b1;
        rd_bank = 1'b1;
        rd_adr  = 2'd3;
        state_d = S_SCAN;
      end
      // cnt 0 consumes the sign read; cnt 1..8 consume segments 0..7.
      S_SCAN: begin
        if (cnt_q < 4'd8) begin
          rd_en   = 1'b1;
          rd_bank = cnt_q[0];
          rd_adr  = cnt_q[2:1];
        end else state_d = S_NORM;
      end
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  state_d = start ? S_SIGN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
  assign busy      = !(state_q == S_IDLE || state_q == S_DONE);
  assign out_valid = (state_q == S_DONE);
  assign mag       = (sign_q ? ~rd_data : rd_data) + {63'b0, carry_q};

  // Rounding: regime run, exponent and fraction laid out MSB-first, then
  // an arithmetic shift stretches the leading regime bit over the run.
  logic signed [10:0] k, run;
  logic               rb, g, st, up;
  logic [10:0]        sh;
  logic [162:0]       x, y;
  logic [30:0]        m;
  logic [31:0]        sum, pmag, res;

  always_comb begin
    k    = scale_q >>> 2;
    rb   = ~k[10];
    run  = rb ? k + 11'sd1 : -k;
    sh   = 11'(run - 11'sd1);
    x    = {rb, ~rb, scale_q[1:0], win_q, 32'b0};
    y    = $signed(x) >>> sh;
    m    = y[162:132];
    g    = y[131];
    st   = (|y[130:0]) | wstk_q;
    up   = g & (st | m[0]);
    sum  = {1'b0, m} + {31'b0, up};
    pmag = sum[31] ? POSIT_MAXPOS : sum;
    if (scale_q > SC_MAX)       pmag = POSIT_MAXPOS;
    else if (scale_q < -SC_MAX) pmag = POSIT_MINPOS;
    if (inf_q)      res = POSIT_NAR;
    else if (!nz_q) res = 32'h0;
    else            res = sign_q ? (~pmag + 32'd1) : pmag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0; inf_q <= 1'b0; sign_q <= 1'b0; carry_q <= 1'b0;
      nz_q <= 1'b0; stk_q <= 1'b0; wstk_q <= 1'b0;
      prev_q <= '0; stk_below_q <= '0; top_q <= '0; next_q <= '0;
      top_idx_q <= '0; win_q <= '0; scale_q <= '0; posit_out <= '0;
    end else begin
      if (accept) begin
        inf_q <= isInf; cnt_q <= '0; nz_q <= 1'b0; stk_q <= 1'b0;
        prev_q <= '0; stk_below_q <= '0; top_q <= '0; next_q <= '0;
        top_idx_q <= '0;
      end
      if (state_q == S_SCAN) begin
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'd0) begin
          sign_q  <= rd_data[63];
          carry_q <= rd_data[63];
        end else begin
          carry_q     <= carry_q & (rd_data == 64'd0);
          prev_q      <= mag;
          stk_below_q <= stk_below_q | {63'b0, |prev_q};
          if (|mag) begin
            nz_q      <= 1'b1;
            top_q     <= mag;
            next_q    <= prev_q;
            stk_q     <= |stk_below_q;
            top_idx_q <= 3'(cnt_q - 4'd1);
          end
        end
      end
      if (state_q == S_NORM) begin
        win_q   <= 127'({top_q, next_q} << lz);
        scale_q <= $signed({2'b0, top_idx_q, 6'b0}) + 11'sd63
                   - $signed({4'b0, lz}) - SC_FP;
        wstk_q  <= stk_q;
      end
      if (state_q == S_ROUND) posit_out <= res;
    end
  end
endmodule

// File: tb/tb_quire_to_posit.sv
// Scoreboard bench: reference posit rounding from the quire value, checked on out_valid.
module tb_quire_to_posit;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, isInf = 1'b0;
  logic        rd_en, rd_bank, busy, out_valid;
  logic [1:0]  rd_adr;
  logic [63:0] rd_data = '0;
  logic [31:0] posit_out;
  logic [511:0] quire = '0;
  int cyc = 0, n_vec = 0, n_err = 0;

  typedef struct { logic [31:0] val; int cyc; int id; } exp_t;
  exp_t exp_q[$];
  int   next_id = 0;

  quire_to_posit dut (
    .clk(clk), .rst(rst), .start(start), .isInf(isInf),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_adr(rd_adr), .rd_data(rd_data),
    .busy(busy), .posit_out(posit_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Segment banks: segment index = {row, bank}; garbage when not read.
  always @(posedge clk)
    rd_data <= rd_en ? quire[{rd_adr, rd_bank} * 64 +: 64] : {$urandom, $urandom};

  function automatic logic [31:0] ref_posit(input logic [511:0] q, input bit inf);
    logic [511:0] a;
    logic [31:0]  mm;
    int p, s, kk, e;
    bit sg, gd, sk;
    bit bq[$];
    if (inf) return 32'h8000_0000;
    if (q == '0) return 32'h0;
    sg = q[511];
    a  = sg ? (~q + 512'd1) : q;
    p  = 511;
    while (!a[p]) p--;
    s = p - 256;
    if (s > 120) mm = 32'h7FFF_FFFF;
    else if (s < -120) mm = 32'h1;
    else begin
      kk = (s >= 0) ? s / 4 : -((-s + 3) / 4);
      e  = s - 4 * kk;
      if (kk >= 0) begin repeat (kk + 1) bq.push_back(1'b1); bq.push_back(1'b0); end
      else begin repeat (-kk) bq.push_back(1'b0); bq.push_back(1'b1); end
      bq.push_back(e[1]); bq.push_back(e[0]);
      for (int i = p - 1; i >= 0; i--) bq.push_back(a[i]);
      while (bq.size() < 33) bq.push_back(1'b0);
      mm = 0;
      for (int i = 0; i < 31; i++) mm = {mm[30:0], bq[i]};
      gd = bq[31];
      sk = 0;
      for (int i = 32; i < bq.size(); i++) sk |= bq[i];
      if (gd && (sk || mm[0])) mm = mm + 1;
      if (mm > 32'h7FFF_FFFF) mm = 32'h7FFF_FFFF;
    end
    return sg ? (~mm + 32'd1) : mm;
  endfunction

  function automatic logic [511:0] bitq(input int i);
    logic [511:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [511:0] rand_quire();
    logic [511:0] v;
    int mode;
    v = '0;
    mode = $urandom_range(0, 2);
    if (mode == 0)
      repeat ($urandom_range(1, 5)) v[$urandom_range(100, 400)] = 1'b1;
    else if (mode == 1)
      v = 512'({$urandom, $urandom}) << $urandom_range(150, 300);
    else
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    if ($urandom_range(0, 1) == 1) v = ~v + 512'd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; issues start at the first negedge with busy low.
  task automatic conv(input logic [511:0] q, input bit inf);
    exp_t e;
    int n = 0;
    while (busy && n < 60) begin @(negedge clk); n++; end
    if (busy) begin
      n_vec++; n_err++;
      $display("FAIL busy_timeout: busy still high after %0d cycles", n);
    end
    quire = q; isInf = inf; start = 1'b1;
    e.val = ref_posit(q, inf); e.cyc = cyc + 13; e.id = next_id++;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; isInf = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out_valid: posit_out=%h at cycle %0d", posit_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (posit_out !== e.val || cyc != e.cyc) begin
          n_err++;
          $display("FAIL result_%0d: posit_out=%h cycle=%0d expected %h cycle=%0d",
                   e.id, posit_out, cyc, e.val, e.cyc);
        end
      end
    end
  end

  initial begin
    int n;
    logic [511:0] q;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_posit_out", 64'(posit_out), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_rd_bank", 64'(rd_bank), 64'd0);
    chk("rst_rd_adr", 64'(rd_adr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    conv(bitq(256), 0);                                   // 1.0
    conv(~bitq(256) + 512'd1, 0);                         // -1.0
    conv(bitq(256) | bitq(255), 0);                       // 1.5
    conv(bitq(256) | bitq(228), 0);                       // tie, stays even
    conv(bitq(256) | bitq(228) | bitq(200), 0);           // above tie
    conv('0, 0);
    conv(rand_quire(), 1);
    conv(bitq(400), 0);
    conv(bitq(56), 0);
    conv(bitq(376), 0);
    conv(bitq(377), 0);
    conv(bitq(136), 0);
    conv(bitq(135), 0);
    conv(bitq(511), 0);                                   // most negative quire
    conv(~bitq(56) + 512'd1, 0);

    // Starts while busy must be dropped.
    conv(bitq(256) | bitq(250), 0);
    repeat (2) @(negedge clk);
    start = 1'b1; isInf = 1'b1; @(negedge clk); start = 1'b0; isInf = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; isInf = 1'b1; @(negedge clk); start = 1'b0; isInf = 1'b0;

    for (int i = 0; i < 40; i++) conv(rand_quire(), ($urandom_range(0, 9) == 0));

    // Reset in the middle of a conversion.
    n = 0;
    while (busy && n < 60) begin @(negedge clk); n++; end
    q = rand_quire();
    quire = q; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_posit_out", 64'(posit_out), 64'd0);
    chk("abort_rd_en", 64'(rd_en), 64'd0);
    chk("abort_rd_bank", 64'(rd_bank), 64'd0);
    chk("abort_rd_adr", 64'(rd_adr), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_output_pending", 64'(exp_q.size()), 64'd0);

    conv(bitq(256), 0);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
